irq_source: RTL and testbench

Memory-mapped interrupt source that drives the processor's CSR interrupt inputs. It combines a prescaled 32-bit machine timer with a compare register, which raises `timer_inter`. It also conditions the raw external interrupt pin (synchroniser, debouncer, edge detector, pending latch), which raises `external_inter`. The block sits on the data-memory bus beside the data memory and clears pending external requests on the CSR's interrupt-taken acknowledge.

---
 rtl/irq_source_if.sv | 10 +
 rtl/irq_source.sv | 65 ++++++
 tb/tb_irq_source.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/irq_source_if.sv
// irq_source_if: memory-mapped bus between the data-memory interconnect and irq_source.
interface irq_source_if;
    logic        bus_sel;
    logic        bus_wr;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    modport master (output bus_sel, bus_wr, bus_addr, bus_wdata, input bus_rdata);
    modport slave  (input bus_sel, bus_wr, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/irq_source.sv
// irq_source: prescaled mtime/mtimecmp timer interrupt plus conditioned, latched external interrupt.
module irq_source #(
    parameter int PRESCALE = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          timer_en,
    input  logic          counter_clear,
    input  logic          ext_inter,
    input  logic          ext_ack,
    irq_source_if.slave   bus,
    output logic          timer_inter,
    output logic          external_inter
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic [PW-1:0] presc;
    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic [1:0]    sync;
    logic          deb;
    logic          deb_d;
    logic          pending;
    logic [DW-1:0] cnt;
    logic          wr0, wr4, wr8, tick, deb_hit, rise;
    assign wr0     = bus.bus_sel && bus.bus_wr && bus.bus_addr == 4'h0;
    assign wr4     = bus.bus_sel && bus.bus_wr && bus.bus_addr == 4'h4;
    assign wr8     = bus.bus_sel && bus.bus_wr && bus.bus_addr == 4'h8;
    assign tick    = timer_en && presc == PW'(PRESCALE - 1);
    assign deb_hit = sync[1] != deb && cnt == DW'(DEBOUNCE - 1);
    assign rise    = deb && !deb_d;
    assign external_inter = pending;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc       <= '0;
            mtime       <= '0;
            mtimecmp    <= '1;
            timer_inter <= 1'b0;
            sync        <= '0;
            deb         <= 1'b0;
            deb_d       <= 1'b0;
            cnt         <= '0;
            pending     <= 1'b0;
        end else begin
            presc       <= (counter_clear || tick) ? '0 : timer_en ? presc + 1'b1 : presc;
            mtime       <= counter_clear ? '0 : wr0 ? bus.bus_wdata : tick ? mtime + 32'd1 : mtime;
            mtimecmp    <= wr4 ? bus.bus_wdata : mtimecmp;
            timer_inter <= timer_en && mtime >= mtimecmp;
            sync        <= {sync[0], ext_inter};
            deb         <= deb_hit ? sync[1] : deb;
            cnt         <= (sync[1] == deb || deb_hit) ? '0 : cnt + 1'b1;
            deb_d       <= deb;
            // a new request outranks a simultaneous acknowledge so it is never lost
            pending     <= rise || (pending && !(ext_ack || (wr8 && bus.bus_wdata[1])));
        end
    end
    always_comb begin
        bus.bus_rdata = '0;
        if (bus.bus_sel && !bus.bus_wr)
            bus.bus_rdata = bus.bus_addr == 4'h0 ? mtime :
                            bus.bus_addr == 4'h4 ? mtimecmp :
                            bus.bus_addr == 4'h8 ? {29'd0, deb, pending, timer_inter} : 32'd0;
    end
endmodule

// File: tb/tb_irq_source.sv
// tb_irq_source: directed checks of timer compare, wrap, clear priority, debounce and pending clear.
module tb_irq_source;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timer_en = 1'b0;
    logic counter_clear = 1'b0;
    logic ext_inter = 1'b0;
    logic ext_ack = 1'b0;
    logic timer_inter;
    logic external_inter;
    int checks = 0;
    int errors = 0;
    irq_source_if bus();
    irq_source #(.PRESCALE(4), .DEBOUNCE(8)) dut (
        .clk(clk), .rst(rst), .timer_en(timer_en), .counter_clear(counter_clear),
        .ext_inter(ext_inter), .ext_ack(ext_ack), .bus(bus),
        .timer_inter(timer_inter), .external_inter(external_inter)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.bus_sel = 1'b1; bus.bus_wr = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
        tick(1);
        bus.bus_sel = 1'b0; bus.bus_wr = 1'b0;
    endtask
    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.bus_sel = 1'b1; bus.bus_wr = 1'b0; bus.bus_addr = a;
        #1;
        d = bus.bus_rdata;
        bus.bus_sel = 1'b0;
    endtask
    task automatic test_reset();
        logic [31:0] r;
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++; if (timer_inter !== 1'b0) begin errors++; $display("FAIL reset_ti got %b exp 0", timer_inter); end
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL reset_ei got %b exp 0", external_inter); end
        bus_read(4'h0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mtime got %h exp 00000000", r); end
        bus_read(4'h4, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got %h exp ffffffff", r); end
        bus_read(4'h8, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 00000000", r); end
        bus_read(4'hC, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 00000000", r); end
    endtask
    task automatic test_timer_compare();
        logic [31:0] r;
        bus_write(4'h4, 32'd5);
        timer_en = 1'b1;
        tick(19);
        bus_read(4'h0, r);
        checks++; if (r !== 32'd4) begin errors++; $display("FAIL mtime_19 got %h exp 4", r); end
        checks++; if (timer_inter !== 1'b0) begin errors++; $display("FAIL ti_early got %b exp 0", timer_inter); end
        tick(1);
        bus_read(4'h0, r);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL mtime_20 got %h exp 5", r); end
        checks++; if (timer_inter !== 1'b0) begin errors++; $display("FAIL ti_latency got %b exp 0", timer_inter); end
        tick(1);
        checks++; if (timer_inter !== 1'b1) begin errors++; $display("FAIL ti_set got %b exp 1", timer_inter); end
        bus_write(4'h4, 32'd100);
        checks++; if (timer_inter !== 1'b1) begin errors++; $display("FAIL ti_cmp_write_edge got %b exp 1", timer_inter); end
        tick(1);
        checks++; if (timer_inter !== 1'b0) begin errors++; $display("FAIL ti_cleared got %b exp 0", timer_inter); end
        timer_en = 1'b0;
    endtask
    task automatic test_clear_priority();
        logic [31:0] r;
        bus_write(4'h0, 32'h1234);
        bus_read(4'h0, r);
        checks++; if (r !== 32'h1234) begin errors++; $display("FAIL mtime_write got %h exp 00001234", r); end
        bus.bus_sel = 1'b1; bus.bus_wr = 1'b1; bus.bus_addr = 4'h0; bus.bus_wdata = 32'h1234;
        counter_clear = 1'b1;
        tick(1);
        bus.bus_sel = 1'b0; bus.bus_wr = 1'b0; counter_clear = 1'b0;
        bus_read(4'h0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL clear_priority got %h exp 00000000", r); end
    endtask
    task automatic test_wrap();
        logic [31:0] r;
        counter_clear = 1'b1;
        tick(1);
        counter_clear = 1'b0;
        bus_write(4'h0, 32'hFFFF_FFFF);
        bus_write(4'h4, 32'hFFFF_FFFF);
        timer_en = 1'b1;
        tick(1);
        checks++; if (timer_inter !== 1'b1) begin errors++; $display("FAIL wrap_ti_set got %b exp 1", timer_inter); end
        tick(3);
        bus_read(4'h0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL wrap_mtime got %h exp 00000000", r); end
        checks++; if (timer_inter !== 1'b1) begin errors++; $display("FAIL wrap_ti_hold got %b exp 1", timer_inter); end
        tick(1);
        checks++; if (timer_inter !== 1'b0) begin errors++; $display("FAIL wrap_ti_clear got %b exp 0", timer_inter); end
        timer_en = 1'b0;
    endtask
    task automatic test_debounce();
        logic [31:0] r;
        ext_inter = 1'b1;
        tick(5);
        ext_inter = 1'b0;
        tick(15);
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL short_pulse got %b exp 0", external_inter); end
        bus_read(4'h8, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL short_status got %h exp 00000000", r); end
        ext_inter = 1'b1;
        tick(10);
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL long_edge9 got %b exp 0", external_inter); end
        bus_read(4'h8, r);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL long_deb_status got %h exp 00000004", r); end
        tick(1);
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL long_edge10 got %b exp 1", external_inter); end
        tick(1);
        ext_inter = 1'b0;
        tick(15);
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL held_after_fall got %b exp 1", external_inter); end
        bus_read(4'h8, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL held_status got %h exp 00000002", r); end
        ext_ack = 1'b1;
        tick(1);
        ext_ack = 1'b0;
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", external_inter); end
    endtask
    task automatic test_collision();
        ext_inter = 1'b1;
        tick(10);
        ext_ack = 1'b1;
        tick(1);
        ext_ack = 1'b0;
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", external_inter); end
        ext_inter = 1'b0;
        tick(15);
        ext_ack = 1'b1;
        tick(1);
        ext_ack = 1'b0;
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL collision_cleanup got %b exp 0", external_inter); end
    endtask
    task automatic test_w1c();
        ext_inter = 1'b1;
        tick(11);
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL w1c_setup got %b exp 1", external_inter); end
        bus_write(4'h8, 32'h5);
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL w1c_bit1_zero got %b exp 1", external_inter); end
        bus_write(4'hC, 32'h2);
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL w1c_unmapped got %b exp 1", external_inter); end
        bus_write(4'h8, 32'h2);
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b exp 0", external_inter); end
        ext_inter = 1'b0;
        tick(15);
    endtask
    task automatic test_async_reset();
        logic [31:0] r;
        bus_write(4'h4, 32'h0);
        timer_en = 1'b1;
        ext_inter = 1'b1;
        tick(11);
        checks++; if (timer_inter !== 1'b1) begin errors++; $display("FAIL pre_reset_ti got %b exp 1", timer_inter); end
        checks++; if (external_inter !== 1'b1) begin errors++; $display("FAIL pre_reset_ei got %b exp 1", external_inter); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (timer_inter !== 1'b0) begin errors++; $display("FAIL async_ti got %b exp 0", timer_inter); end
        checks++; if (external_inter !== 1'b0) begin errors++; $display("FAIL async_ei got %b exp 0", external_inter); end
        bus_read(4'h4, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_cmp got %h exp ffffffff", r); end
        timer_en = 1'b0;
        ext_inter = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        bus_read(4'h0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL post_reset_mtime got %h exp 00000000", r); end
        bus_read(4'h8, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL post_reset_status got %h exp 00000000", r); end
    endtask
    initial begin
        bus.bus_sel = 1'b0; bus.bus_wr = 1'b0; bus.bus_addr = 4'h0; bus.bus_wdata = 32'h0;
        test_reset();
        test_timer_compare();
        test_clear_priority();
        test_wrap();
        test_debounce();
        test_collision();
        test_w1c();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
